// File: rtl/huff_pkg.sv
// Shared constants, record layout and FSM encoding for the Huffman code generator.
// The optional HUFF_LOOP_CHECK_EN macro turns on malformed-tree detection.
package huff_pkg;
    localparam int N_NODE     = 7;
    localparam int N_LEAF     = 4;
    localparam int MAX_DEPTH  = 6;
    localparam int REC_W      = 13;
    localparam logic [3:0] ROOT_NIL = 4'hF;

    localparam int PARENT_HI  = 12;
    localparam int PARENT_LO  = 9;
    localparam int BRANCH_BIT = 8;
    localparam int WEIGHT_HI  = 7;
    localparam int WEIGHT_LO  = 0;

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_EMIT, S_DONE} state_t;

    // A parent link is usable only when it names a real node.
    function automatic logic parent_ok(input logic [3:0] p);
        return (p != 4'd0) && (p <= 4'(N_NODE));
    endfunction
endpackage

// File: rtl/huff_node_ram.sv
// Node table: 7 x 13-bit records, synchronous write, asynchronous read,
// asynchronous clear. Address 0 is not a node and reads back as zero.
module huff_node_ram
    import huff_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [REC_W-1:0] wr_data,
    input  logic [2:0]       rd_addr,
    output logic [3:0]       rd_parent,
    output logic             rd_branch,
    output logic [7:0]       rd_weight
);
    logic [REC_W-1:0] mem [1:N_NODE];
    logic [REC_W-1:0] rd_rec;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 1; i <= N_NODE; i++) mem[i] <= '0;
        end else if (wr_en && wr_addr != 3'd0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_rec    = (rd_addr == 3'd0) ? '0 : mem[rd_addr];
    assign rd_parent = rd_rec[PARENT_HI:PARENT_LO];
    assign rd_branch = rd_rec[BRANCH_BIT];
    assign rd_weight = rd_rec[WEIGHT_HI:WEIGHT_LO];
endmodule

// File: rtl/huff_code_gen.sv
// Walks leaf-to-root through the node table and emits one code per leaf 1..4.
// Define HUFF_LOOP_CHECK_EN to abort on bad parents / over-deep trees with a sticky err.
module huff_code_gen
    import huff_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        node_wr,
    input  logic [2:0]  node_addr,
    input  logic [12:0] node_data,
    input  logic        start,
    input  logic        code_ready,
    output logic        code_valid,
    output logic [2:0]  code_sym,
    output logic [7:0]  code_bits,
    output logic [3:0]  code_len,
    output logic        busy,
    output logic        done,
    output logic        err
);
    state_t      state;
    logic [2:0]  cur;
    logic [2:0]  leaf;
    logic [7:0]  acc_bits;
    logic [3:0]  acc_len;
    logic [3:0]  parent;
    logic        branch;
    logic [7:0]  weight;
    logic        unused_weight;
    logic        is_root;
    logic        at_limit;
    logic        emit_now;
    logic        abort_now;

    huff_node_ram u_ram (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (node_wr && state == S_IDLE),
        .wr_addr   (node_addr),
        .wr_data   (node_data),
        .rd_addr   (cur),
        .rd_parent (parent),
        .rd_branch (branch),
        .rd_weight (weight)
    );

    // Weights are kept in the table for software but play no part in the walk.
    assign unused_weight = ^weight;
    assign is_root       = (parent == ROOT_NIL);

`ifdef HUFF_LOOP_CHECK_EN
    logic err_q;
    assign err       = err_q;
    assign at_limit  = (acc_len == 4'(MAX_DEPTH));
    assign emit_now  = is_root;
    assign abort_now = !is_root && (!parent_ok(parent) || at_limit);
`else
    assign err       = 1'b0;
    assign at_limit  = (acc_len == 4'(MAX_DEPTH + 1));
    assign emit_now  = is_root || !parent_ok(parent) || at_limit;
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            cur        <= '0;
            leaf       <= '0;
            acc_bits   <= '0;
            acc_len    <= '0;
            code_valid <= 1'b0;
            code_sym   <= '0;
            code_bits  <= '0;
            code_len   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef HUFF_LOOP_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_WALK;
                    busy     <= 1'b1;
                    cur      <= 3'd1;
                    leaf     <= 3'd1;
                    acc_bits <= '0;
                    acc_len  <= '0;
`ifdef HUFF_LOOP_CHECK_EN
                    err_q    <= 1'b0;
`endif
                end
                S_WALK: begin
                    if (emit_now) begin
                        state      <= S_EMIT;
                        code_valid <= 1'b1;
                        code_sym   <= leaf;
                        code_bits  <= acc_bits;
                        code_len   <= acc_len;
                    end else if (abort_now) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
`ifdef HUFF_LOOP_CHECK_EN
                        err_q <= 1'b1;
`endif
                    end else begin
                        // Leaf edge lands in bit 0; each step up shifts the next edge left.
                        acc_bits <= acc_bits | (8'(branch) << acc_len);
                        acc_len  <= acc_len + 4'd1;
                        cur      <= parent[2:0];
                    end
                end
                S_EMIT: if (code_ready) begin
                    code_valid <= 1'b0;
                    if (leaf == 3'(N_LEAF)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_WALK;
                        leaf     <= leaf + 3'd1;
                        cur      <= leaf + 3'd1;
                        acc_bits <= '0;
                        acc_len  <= '0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huff_code_gen.sv
// Self-checking bench for huff_code_gen: directed trees plus random tables checked
// against a leaf-to-root walk model; honours HUFF_LOOP_CHECK_EN like the design.
module tb_huff_code_gen;
    logic        CLK = 1'b0;
    logic        RST;
    logic        node_wr;
    logic [2:0]  node_addr;
    logic [12:0] node_data;
    logic        start;
    logic        code_ready;
    logic        code_valid;
    logic [2:0]  code_sym;
    logic [7:0]  code_bits;
    logic [3:0]  code_len;
    logic        busy;
    logic        done;
    logic        err;

    int ncmp  = 0;
    int nfail = 0;
    logic [12:0] tbl [1:7];

    always #5 CLK = ~CLK;

    huff_code_gen dut (
        .CLK        (CLK),
        .RST        (RST),
        .node_wr    (node_wr),
        .node_addr  (node_addr),
        .node_data  (node_data),
        .start      (start),
        .code_ready (code_ready),
        .code_valid (code_valid),
        .code_sym   (code_sym),
        .code_bits  (code_bits),
        .code_len   (code_len),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] rec(input logic [3:0] p, input logic b, input logic [7:0] w);
        return {p, b, w};
    endfunction

    // Code of a leaf straight from the tree rules: follow parents to the root,
    // placing each edge bit above the ones already collected.
    function automatic void model(input int lf, output logic [7:0] b, output int l, output bit bad);
        int c;
        logic [3:0] p;
        c = lf; b = '0; l = 0; bad = 1'b0;
        for (int step = 0; step < 16; step++) begin
            p = tbl[c][12:9];
            if (p == 4'hF) return;
`ifdef HUFF_LOOP_CHECK_EN
            if (p == 0 || p > 7 || l == 6) begin bad = 1'b1; return; end
`else
            if (p == 0 || p > 7 || l == 7) return;
`endif
            b[l] = tbl[c][8];
            l++;
            c = int'(p);
        end
    endfunction

    task automatic wr_node(input logic [2:0] a, input logic [12:0] d);
        node_wr = 1'b1; node_addr = a; node_data = d;
        @(negedge CLK);
        node_wr = 1'b0;
        if (a != 3'd0) tbl[a] = d;
    endtask

    task automatic wr_balanced();
        wr_node(1, rec(4'd5, 0, 8'd10)); wr_node(2, rec(4'd5, 1, 8'd12));
        wr_node(3, rec(4'd6, 0, 8'd20)); wr_node(4, rec(4'd6, 1, 8'd25));
        wr_node(5, rec(4'd7, 0, 8'd22)); wr_node(6, rec(4'd7, 1, 8'd45));
        wr_node(7, rec(4'hF, 0, 8'd67));
    endtask

    // One full walk from start; called at a negedge with the DUT idle.
    task automatic run_walk(input int stall_leaf, input int stall_n, input bit rnd,
                            input bit bw, input bit cw, input logic [2:0] ca, input logic [12:0] cd);
        logic [7:0] eb;
        int el, stall, k;
        bit ebad, got, aborted;
        aborted = 1'b0;
        if (cw) begin
            node_wr = 1'b1; node_addr = ca; node_data = cd;
            if (ca != 3'd0) tbl[ca] = cd;
        end
        start = 1'b1; code_ready = 1'b1;
        for (int lf = 1; lf <= 4 && !aborted; lf++) begin
            model(lf, eb, el, ebad);
            stall = (lf == stall_leaf) ? stall_n : (rnd ? int'($urandom_range(0, 3)) : 0);
            got = 1'b0;
            for (k = 1; k <= 40; k++) begin
                @(negedge CLK);
                start = 1'b0; node_wr = 1'b0;
                if (bw && lf == 1 && k == 1) begin
                    node_wr = 1'b1; node_addr = 3'd1; node_data = 13'($urandom);
                end
                if (stall > 0) code_ready = 1'b0;
                if (code_valid) begin got = 1'b1; break; end
                if (!busy) break;
            end
            node_wr = 1'b0;
            if (ebad) begin
                check("abort_no_valid", 32'(got), 32'd0);
                check("abort_err", 32'(err), 32'd1);
                check("abort_busy", 32'(busy), 32'd0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge CLK);
                    check("abort_no_done", 32'(done), 32'd0);
                end
                aborted = 1'b1;
            end else begin
                check("valid_seen", 32'(got), 32'd1);
                check("latency", 32'(k), 32'(el + 2));
                check("code_sym", 32'(code_sym), 32'(lf));
                check("code_bits", 32'(code_bits), 32'(eb));
                check("code_len", 32'(code_len), 32'(el));
                for (int s = 0; s < stall; s++) begin
                    @(negedge CLK);
                    check("hold_valid", 32'(code_valid), 32'd1);
                    check("hold_sym", 32'(code_sym), 32'(lf));
                    check("hold_bits", 32'(code_bits), 32'(eb));
                    check("hold_len", 32'(code_len), 32'(el));
                end
                code_ready = 1'b1;
            end
        end
        if (!aborted) begin
            @(negedge CLK);
            check("done_pulse", 32'(done), 32'd1);
            check("done_busy", 32'(busy), 32'd1);
            check("done_no_valid", 32'(code_valid), 32'd0);
            @(negedge CLK);
            check("done_clear", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_err", 32'(err), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(code_valid), 32'd0);
        check({tag, "_sym"}, 32'(code_sym), 32'd0);
        check({tag, "_bits"}, 32'(code_bits), 32'd0);
        check({tag, "_len"}, 32'(code_len), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bit found;
        RST = 1'b1; node_wr = 1'b0; node_addr = '0; node_data = '0;
        start = 1'b0; code_ready = 1'b1;
        for (int i = 1; i <= 7; i++) tbl[i] = '0;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Balanced tree, then the same tree with sym2 backpressured.
        wr_balanced();
        run_walk(0, 0, 0, 0, 0, 3'd0, 13'd0);
        run_walk(2, 5, 0, 0, 0, 3'd0, 13'd0);

        // Skewed tree.
        wr_node(1, rec(4'd5, 0, 8'd1)); wr_node(2, rec(4'd5, 1, 8'd2));
        wr_node(3, rec(4'd6, 1, 8'd3)); wr_node(5, rec(4'd6, 0, 8'd4));
        wr_node(4, rec(4'd7, 1, 8'd5)); wr_node(6, rec(4'd7, 0, 8'd6));
        wr_node(7, rec(4'hF, 0, 8'd7));
        run_walk(0, 0, 0, 0, 0, 3'd0, 13'd0);

        // Writes while busy are dropped: a second walk must repeat the first.
        wr_balanced();
        run_walk(0, 0, 0, 1, 0, 3'd0, 13'd0);
        run_walk(0, 0, 0, 0, 0, 3'd0, 13'd0);

        // Write and start in the same cycle: the walk uses the new record.
        run_walk(0, 0, 0, 0, 1, 3'd4, rec(4'd6, 0, 8'd99));

        // Reset during the walk of sym3.
        wr_balanced();
        start = 1'b1; code_ready = 1'b1; found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            start = 1'b0;
            if (code_valid && code_sym == 3'd2) begin found = 1'b1; break; end
        end
        check("rst_reach_sym2", 32'(found), 32'd1);
        @(negedge CLK);
        check("rst_pre_busy", 32'(busy), 32'd1);
        RST = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(negedge CLK);
        check_all_zero("rst_held");
        RST = 1'b0;
        for (int i = 1; i <= 7; i++) tbl[i] = '0;
        @(negedge CLK);
        check_all_zero("rst_after");
        run_walk(0, 0, 0, 0, 0, 3'd0, 13'd0);

        // Self-loop at node 5.
        wr_balanced();
        wr_node(5, rec(4'd5, 0, 8'd22));
        run_walk(0, 0, 0, 0, 0, 3'd0, 13'd0);

        // Random tables (including bad parents and loops) with random stalls.
        for (int r = 0; r < 6; r++) begin
            for (int a = 1; a <= 7; a++)
                wr_node(3'(a), rec(4'($urandom_range(0, 15)), 1'($urandom), 8'($urandom)));
            wr_node(3'd0, 13'($urandom));
            run_walk(0, 0, 1, 0, 0, 3'd0, 13'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
